// File: rtl/serial_adder_pkg.sv
// serial_adder_pkg
// Shared definitions for the bit-serial adder.
//   state_t   : FSM state encoding (IDLE, SHIFT, DONE)
//   cnt_width : width of the bit counter needed to count WIDTH shift edges
package serial_adder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_t;

  // The counter must hold values 0..WIDTH-1. WIDTH=1 still needs a
  // one-bit register, so clamp the result to at least 1.
  function automatic int cnt_width(input int width);
    return (width <= 1) ? 1 : $clog2(width);
  endfunction

endpackage

// File: rtl/serial_adder_fa_bit.sv
// fa_bit
// Purely combinational one-bit full adder. This is the single arithmetic
// cell shared by every bit position of the serial adder.
// Ports:
//   a, b   : operand bits
//   cin    : carry in
//   sum    : a ^ b ^ cin
//   carry  : majority(a, b, cin)
module fa_bit (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic sum,
  output logic carry
);

  assign sum   = a ^ b ^ cin;
  assign carry = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/serial_adder.sv
// serial_adder
// Bit-serial ripple adder: computes a + b + cin for WIDTH-bit operands,
// one bit per clock, using a single fa_bit cell and a carry flip-flop.
// Latency is WIDTH cycles in SHIFT plus one DONE cycle.
// Parameters:
//   WIDTH : operand/result width, 1..32
// Ports:
//   clk, rst : clock and asynchronous active-high reset
//   start    : request a new addition (only sampled in IDLE)
//   a, b     : operands, captured on the accepting edge
//   cin      : carry in, captured on the accepting edge
//   busy     : high while shifting
//   done     : one-cycle pulse when a result is presented
//   sum      : result of the last completed addition (held)
//   cout     : carry out of the last completed addition (held)
//   ovf      : signed overflow of the last completion; only present when
//              the SERIAL_ADDER_OVF_EN macro is defined
module serial_adder
  import serial_adder_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
`ifdef SERIAL_ADDER_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int            CW   = cnt_width(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic [WIDTH-1:0] a_sh;
  logic [WIDTH-1:0] b_sh;
  logic [WIDTH-1:0] res_sh;
  logic [WIDTH-1:0] res_next;
  logic [CW-1:0]    cnt;
  logic             carry;
  logic             s;
  logic             c;
  logic             last_bit;

  // The one and only adder cell always sees the current LSB pair and the
  // stored carry; the sequencing below decides when its output is used.
  fa_bit u_fa (
    .a     (a_sh[0]),
    .b     (b_sh[0]),
    .cin   (carry),
    .sum   (s),
    .carry (c)
  );

  // New sum bit enters at the MSB so that after WIDTH shifts the first
  // (least significant) bit has travelled down to bit 0. Written as a
  // shift/or so it stays legal for WIDTH=1.
  assign res_next = (res_sh >> 1) | (WIDTH'(s) << (WIDTH - 1));
  assign last_bit = (cnt == LAST);

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status decode. busy/done come straight from the state
  // register, so they carry no combinational path from any input.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_SHIFT;
      end
      ST_SHIFT: begin
        busy = 1'b1;
        if (last_bit) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand load on acceptance, one bit per SHIFT edge, and the
  // result registers updated only on the final shift edge so they hold the
  // previous answer throughout the next operation.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh   <= '0;
      b_sh   <= '0;
      res_sh <= '0;
      cnt    <= '0;
      carry  <= 1'b0;
      sum    <= '0;
      cout   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
      ovf    <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (start) begin
            a_sh   <= a;
            b_sh   <= b;
            carry  <= cin;
            cnt    <= '0;
            res_sh <= '0;
          end
        end
        ST_SHIFT: begin
          a_sh   <= a_sh >> 1;
          b_sh   <= b_sh >> 1;
          res_sh <= res_next;
          carry  <= c;
          cnt    <= cnt + CW'(1);
          if (last_bit) begin
            sum  <= res_next;
            cout <= c;
`ifdef SERIAL_ADDER_OVF_EN
            // On the MSB step the stored carry is the carry into the MSB.
            ovf  <= carry ^ c;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_adder.sv
// tb_serial_adder
// Self-checking bench for serial_adder (WIDTH=8). Stimulus pushes expected
// results into a queue; an independent monitor pops and compares whenever
// done is presented, also checking completion timing and busy length.
// Build with SERIAL_ADDER_OVF_EN defined to also check ovf.
module tb_serial_adder;

  localparam int W = 8;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    int           due;
  } exp_t;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
`ifdef SERIAL_ADDER_OVF_EN
  logic         ovf;
`endif

  int   num_tests  = 0;
  int   num_failed = 0;
  int   cyc        = 0;
  int   done_seen  = 0;
  exp_t exp_q[$];

  serial_adder #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout)
`ifdef SERIAL_ADDER_OVF_EN
    ,
    .ovf   (ovf)
`endif
  );

  // Free-running clock and an edge counter used as the time base.
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Reference model: plain integer arithmetic on the operands.
  function automatic exp_t model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                 input logic mcin, input int due);
    exp_t        e;
    logic [W:0]  full;
    longint      sa;
    longint      sb;
    longint      ssum;
    full = {1'b0, ma} + {1'b0, mb} + {{W{1'b0}}, mcin};
    e.sum  = full[W-1:0];
    e.cout = full[W];
    sa   = ma[W-1] ? longint'(ma) - (longint'(1) << W) : longint'(ma);
    sb   = mb[W-1] ? longint'(mb) - (longint'(1) << W) : longint'(mb);
    ssum = sa + sb + longint'(mcin);
    e.ovf = (ssum > ((longint'(1) << (W - 1)) - 1)) || (ssum < -(longint'(1) << (W - 1)));
    e.due = due;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    num_tests++;
    if (actual !== expected) begin
      num_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, actual, expected, cyc);
    end
  endtask

  task automatic reportTimeout(input string name);
    num_tests++;
    num_failed++;
    $display("[TB] FAIL %s: wait bound expired, got timeout, expected event (cycle %0d)", name, cyc);
  endtask

  // Waits for an IDLE cycle (seen at the falling edge), then issues one
  // request that the next rising edge accepts.
  task automatic waitIdle();
    int guard = 0;
    @(negedge clk);
    while ((busy || done) && guard < 100) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 100) reportTimeout("idle_wait");
  endtask

  task automatic applyStimulus(input logic [W-1:0] sa, input logic [W-1:0] sb,
                               input logic scin);
    waitIdle();
    a     = sa;
    b     = sb;
    cin   = scin;
    start = 1'b1;
    exp_q.push_back(model(sa, sb, scin, cyc + 1 + W));
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
  endtask

  // Monitor: pops an expectation whenever done is high; otherwise checks
  // that the result outputs are holding.
  logic [W-1:0] last_sum  = '0;
  logic         last_cout = 1'b0;
  int           busy_cnt  = 0;

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        last_sum  = '0;
        last_cout = 1'b0;
        busy_cnt  = 0;
      end else begin
        if (busy) busy_cnt++;
        if (done) begin
          done_seen++;
          if (exp_q.size() == 0) begin
            checkOutput("unexpected_done", 32'(done), 32'(0));
          end else begin
            e = exp_q.pop_front();
            checkOutput("sum", 32'(sum), 32'(e.sum));
            checkOutput("cout", 32'(cout), 32'(e.cout));
`ifdef SERIAL_ADDER_OVF_EN
            checkOutput("ovf", 32'(ovf), 32'(e.ovf));
`endif
            checkOutput("done_cycle", 32'(cyc), 32'(e.due));
            checkOutput("busy_len", 32'(busy_cnt), 32'(W));
          end
          last_sum  = sum;
          last_cout = cout;
          busy_cnt  = 0;
        end else begin
          checkOutput("sum_hold", 32'(sum), 32'(last_sum));
          checkOutput("cout_hold", 32'(cout), 32'(last_cout));
        end
      end
    end
  end

  initial begin
    logic [W-1:0] b2;
    int           seen;
    int           guard;

    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;

    // Reset state.
    @(negedge clk);
    checkOutput("rst_busy", 32'(busy), 32'(0));
    checkOutput("rst_done", 32'(done), 32'(0));
    checkOutput("rst_sum", 32'(sum), 32'(0));
    checkOutput("rst_cout", 32'(cout), 32'(0));
`ifdef SERIAL_ADDER_OVF_EN
    checkOutput("rst_ovf", 32'(ovf), 32'(0));
`endif
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Directed cases, including carry out of the MSB and carry-in ripple.
    applyStimulus(8'h5A, 8'h33, 1'b0);
    applyStimulus(8'hFF, 8'h01, 1'b0);
    applyStimulus(8'hFF, 8'h00, 1'b1);
    applyStimulus(8'h7F, 8'h01, 1'b0);
    applyStimulus(8'h80, 8'hFF, 1'b0);

    // start held through SHIFT and DONE: only the first IDLE edge accepts.
    waitIdle();
    b2    = W'($urandom);
    a     = 8'h10;
    b     = 8'h20;
    cin   = 1'b0;
    start = 1'b1;
    exp_q.push_back(model(8'h10, 8'h20, 1'b0, cyc + 1 + W));
    exp_q.push_back(model(8'hFF, b2, 1'b0, cyc + 1 + (W + 2) + W));
    @(posedge clk);
    #1;
    a = 8'hFF;
    b = b2;
    repeat (W + 2) @(posedge clk);
    #1;
    start = 1'b0;

    // Reset in the middle of an operation: no done, all outputs cleared.
    applyStimulus(8'hC3, 8'h5C, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    exp_q.delete();
    @(negedge clk);
    checkOutput("abort_busy", 32'(busy), 32'(0));
    checkOutput("abort_done", 32'(done), 32'(0));
    checkOutput("abort_sum", 32'(sum), 32'(0));
    checkOutput("abort_cout", 32'(cout), 32'(0));
    @(posedge clk);
    #1;
    rst  = 1'b0;
    seen = done_seen;
    repeat (W + 4) @(posedge clk);
    #1;
    checkOutput("abort_no_done", 32'(done_seen), 32'(seen));
    applyStimulus(8'h01, 8'h01, 1'b0);

    // Back-to-back random traffic, each request in the first IDLE cycle.
    for (int i = 0; i < 25; i++) begin
      applyStimulus(W'($urandom), W'($urandom), 1'($urandom));
    end
    applyStimulus(8'hFF, 8'hFF, 1'b1);
    applyStimulus(8'h00, 8'h00, 1'b0);

    // Drain the scoreboard with a bounded wait.
    guard = 0;
    while (exp_q.size() != 0 && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    if (exp_q.size() != 0) reportTimeout("drain");
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", num_tests, num_failed);
    $finish;
  end

endmodule
